// File: rtl/demod_pkg.sv
// Shared types and helpers for the conjugate-multiply discriminator front end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package demod_pkg;

    localparam int IQ_W_DEF = 16;

    // One complex sample as it travels on the input stream: Q in the upper half.
    typedef struct packed {
        logic signed [IQ_W_DEF-1:0] im;
        logic signed [IQ_W_DEF-1:0] re;
    } iq_t;

    // Width of the channel index; a single channel still needs a 1-bit tuser.
    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Clamp a sign-extended value into the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_to_w(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/demod_cmul_stage.sv
// Two-register complex conjugate multiply: products, then sum/shift/saturate.
// Latency: 2 cycles from in_en to out_valid when out_en stays high.
// Backpressure: out_en freezes the output register; stage 1 holds until stage 2 frees up.
// Ports: in_en loads stage 1 with (a+jb)*conj(c+jd) partial products plus sideband;
//        out_en advances stage 1 into the output register; s1_valid reports occupancy.
module demod_cmul_stage
    import demod_pkg::*;
#(
    parameter int IQ_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 1,
    parameter int CH_W  = 1
) (
    input  logic                   s00_axis_aclk,
    input  logic                   s00_axis_aresetn,
    input  logic                   in_en,
    input  logic signed [IQ_W-1:0] in_a,
    input  logic signed [IQ_W-1:0] in_b,
    input  logic signed [IQ_W-1:0] in_c,
    input  logic signed [IQ_W-1:0] in_d,
    input  logic                   in_hv,
    input  logic [CH_W-1:0]        in_ch,
    input  logic                   in_last,
    input  logic                   out_en,
    output logic                   s1_valid,
    output logic                   out_valid,
    output logic signed [OUT_W-1:0] out_re,
    output logic signed [OUT_W-1:0] out_im,
    output logic [CH_W-1:0]        out_ch,
    output logic                   out_last
);

    localparam int PW = 2 * IQ_W;
    localparam int SW = 2 * IQ_W + 1;

    logic signed [PW-1:0] p_ac;
    logic signed [PW-1:0] p_bd;
    logic signed [PW-1:0] p_bc;
    logic signed [PW-1:0] p_ad;
    logic                 s1_hv;
    logic [CH_W-1:0]      s1_ch;
    logic                 s1_last;

    logic signed [SW-1:0] sum_re;
    logic signed [SW-1:0] sum_im;

    // One extra bit so ac+bd and bc-ad never wrap before the shift.
    always_comb begin
        sum_re = SW'(p_ac) + SW'(p_bd);
        sum_im = SW'(p_bc) - SW'(p_ad);
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            s1_valid <= 1'b0;
            p_ac     <= '0;
            p_bd     <= '0;
            p_bc     <= '0;
            p_ad     <= '0;
            s1_hv    <= 1'b0;
            s1_ch    <= '0;
            s1_last  <= 1'b0;
        end else begin
            if (in_en) begin
                s1_valid <= 1'b1;
                p_ac     <= in_a * in_c;
                p_bd     <= in_b * in_d;
                p_bc     <= in_b * in_c;
                p_ad     <= in_a * in_d;
                s1_hv    <= in_hv;
                s1_ch    <= in_ch;
                s1_last  <= in_last;
            end else if (out_en) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
        end else if (out_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                // No history yet for this channel: emit zero rather than a product with reset state.
                out_re   <= s1_hv ? OUT_W'(sat_to_w(64'(sum_re >>> SHIFT), OUT_W)) : '0;
                out_im   <= s1_hv ? OUT_W'(sat_to_w(64'(sum_im >>> SHIFT), OUT_W)) : '0;
                out_ch   <= s1_ch;
                out_last <= s1_last;
            end
        end
    end

endmodule

// File: rtl/demod_conj_mult_nch.sv
// Multi-channel FM discriminator front end: y = x[n]*conj(x_k[n-1]), scaled and saturated.
// Latency: 2 cycles accept -> m00_axis_tvalid; one beat per cycle sustained.
// Backpressure: up to 2 beats buffered while m00_axis_tready is low, then s00_axis_tready drops.
// Ports: s00_axis_* carries interleaved IQ beats (I low, Q high); m00_axis_* carries {imag, real}
//        with the channel index on tuser and the producing beat's tlast; tstrb is all ones when valid.
module demod_conj_mult_nch
    import demod_pkg::*;
#(
    parameter int IQ_W           = 16,
    parameter int OUT_W          = 32,
    parameter int NUM_CH         = 1,
    parameter int SHIFT          = 1,
    parameter int RESET_ON_TLAST = 1,
    localparam int C_S00_AXIS_TDATA_WIDTH = 2 * IQ_W,
    localparam int C_M00_AXIS_TDATA_WIDTH = 2 * OUT_W,
    localparam int CH_W                   = ch_w(NUM_CH)
) (
    input  logic                              s00_axis_aclk,
    input  logic                              s00_axis_aresetn,
    input  logic                              s00_axis_tvalid,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                              s00_axis_tlast,
    input  logic [IQ_W/4-1:0]                 s00_axis_tstrb,
    output logic                              s00_axis_tready,
    input  logic                              m00_axis_tready,
    output logic                              m00_axis_tvalid,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
    output logic                              m00_axis_tlast,
    output logic [OUT_W/4-1:0]                m00_axis_tstrb,
    output logic [CH_W-1:0]                   m00_axis_tuser
);

    logic                   s1_valid;
    logic                   out_en;
    logic                   accept;
    logic                   unused_tstrb;

    logic [2*IQ_W-1:0]      hist [NUM_CH];
    logic [NUM_CH-1:0]      hist_valid;
    logic [CH_W-1:0]        ch_cnt;
    logic [2*IQ_W-1:0]      hist_rd;

    logic signed [OUT_W-1:0] out_re;
    logic signed [OUT_W-1:0] out_im;

    assign unused_tstrb = ^s00_axis_tstrb;

    // Output register can load when empty or when its beat is leaving this cycle.
    assign out_en          = m00_axis_tready || !m00_axis_tvalid;
    assign s00_axis_tready = !s1_valid || out_en;
    assign accept          = s00_axis_tvalid && s00_axis_tready;

    assign hist_rd = hist[ch_cnt];

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                hist[i] <= '0;
            end
            hist_valid <= '0;
            ch_cnt     <= '0;
        end else if (accept) begin
            // A frame boundary realigns the interleave to channel 0.
            if (s00_axis_tlast || ch_cnt == CH_W'(NUM_CH - 1)) begin
                ch_cnt <= '0;
            end else begin
                ch_cnt <= ch_cnt + CH_W'(1);
            end
            // With frame reset enabled the tlast beat must not seed the next frame.
            if (RESET_ON_TLAST != 0 && s00_axis_tlast) begin
                hist_valid <= '0;
            end else begin
                hist[ch_cnt]       <= s00_axis_tdata;
                hist_valid[ch_cnt] <= 1'b1;
            end
        end
    end

    demod_cmul_stage #(
        .IQ_W  (IQ_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT),
        .CH_W  (CH_W)
    ) u_cmul (
        .s00_axis_aclk    (s00_axis_aclk),
        .s00_axis_aresetn (s00_axis_aresetn),
        .in_en            (accept),
        .in_a             (s00_axis_tdata[IQ_W-1:0]),
        .in_b             (s00_axis_tdata[2*IQ_W-1:IQ_W]),
        .in_c             (hist_rd[IQ_W-1:0]),
        .in_d             (hist_rd[2*IQ_W-1:IQ_W]),
        .in_hv            (hist_valid[ch_cnt]),
        .in_ch            (ch_cnt),
        .in_last          (s00_axis_tlast),
        .out_en           (out_en),
        .s1_valid         (s1_valid),
        .out_valid        (m00_axis_tvalid),
        .out_re           (out_re),
        .out_im           (out_im),
        .out_ch           (m00_axis_tuser),
        .out_last         (m00_axis_tlast)
    );

    assign m00_axis_tdata = {out_im, out_re};
    assign m00_axis_tstrb = {(OUT_W/4){m00_axis_tvalid}};

endmodule

// File: tb/tb_demod_conj_mult_nch.sv
// Bench for demod_conj_mult_nch: three parameterisations share one input stream and handshake.
// dut0 NUM_CH=1 tlast-reset; dut1 NUM_CH=2 no tlast-reset; dut2 OUT_W=16 for saturation.
// Outputs are scored against an arithmetic model plus directed vector tables.
module tb_demod_conj_mult_nch;
    import demod_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_tvalid;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic [3:0]  s_tstrb;
    logic        m_tready;

    logic        s_tready0, s_tready1, s_tready2;
    logic        m_tvalid0, m_tvalid1, m_tvalid2;
    logic [63:0] m_tdata0, m_tdata1;
    logic [31:0] m_tdata2;
    logic        m_tlast0, m_tlast1, m_tlast2;
    logic [7:0]  m_tstrb0, m_tstrb1;
    logic [3:0]  m_tstrb2;
    logic        m_tuser0, m_tuser1, m_tuser2;

    always #5 clk = ~clk;

    demod_conj_mult_nch #(.NUM_CH(1), .RESET_ON_TLAST(1)) u_dut0 (
        .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n), .s00_axis_tvalid(s_tvalid),
        .s00_axis_tdata(s_tdata), .s00_axis_tlast(s_tlast), .s00_axis_tstrb(s_tstrb),
        .s00_axis_tready(s_tready0), .m00_axis_tready(m_tready), .m00_axis_tvalid(m_tvalid0),
        .m00_axis_tdata(m_tdata0), .m00_axis_tlast(m_tlast0), .m00_axis_tstrb(m_tstrb0),
        .m00_axis_tuser(m_tuser0));

    demod_conj_mult_nch #(.NUM_CH(2), .RESET_ON_TLAST(0)) u_dut1 (
        .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n), .s00_axis_tvalid(s_tvalid),
        .s00_axis_tdata(s_tdata), .s00_axis_tlast(s_tlast), .s00_axis_tstrb(s_tstrb),
        .s00_axis_tready(s_tready1), .m00_axis_tready(m_tready), .m00_axis_tvalid(m_tvalid1),
        .m00_axis_tdata(m_tdata1), .m00_axis_tlast(m_tlast1), .m00_axis_tstrb(m_tstrb1),
        .m00_axis_tuser(m_tuser1));

    demod_conj_mult_nch #(.NUM_CH(1), .OUT_W(16), .RESET_ON_TLAST(1)) u_dut2 (
        .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n), .s00_axis_tvalid(s_tvalid),
        .s00_axis_tdata(s_tdata), .s00_axis_tlast(s_tlast), .s00_axis_tstrb(s_tstrb),
        .s00_axis_tready(s_tready2), .m00_axis_tready(m_tready), .m00_axis_tvalid(m_tvalid2),
        .m00_axis_tdata(m_tdata2), .m00_axis_tlast(m_tlast2), .m00_axis_tstrb(m_tstrb2),
        .m00_axis_tuser(m_tuser2));

    typedef struct {
        longint re;
        longint im;
        int     user;
        bit     last;
    } beat_t;

    typedef struct {
        int     grp;
        int     i;
        int     q;
        bit     last;
        int     dut;
        longint re;
        longint im;
        int     user;
    } vec_t;

    int     checks = 0;
    int     errors = 0;
    vec_t   vecs[$];
    beat_t  exp_q[3][$];
    beat_t  log_q[3][$];
    beat_t  held[3];
    bit     held_v[3];

    // Reference model state, per DUT configuration.
    int     nch[3]  = '{1, 2, 1};
    int     outw[3] = '{32, 32, 16};
    bit     rot[3]  = '{1'b1, 1'b0, 1'b1};
    longint m_hi[3][16];
    longint m_hq[3][16];
    bit     m_hv[3][16];
    int     m_ch[3];

    function automatic void chk(string name, longint got, longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 16; c++) begin
                m_hi[k][c] = 0;
                m_hq[k][c] = 0;
                m_hv[k][c] = 1'b0;
            end
            m_ch[k] = 0;
            held_v[k] = 1'b0;
            exp_q[k].delete();
            log_q[k].delete();
        end
    endfunction

    // y = x * conj(h) = (a+jb)(c-jd), floored by SHIFT=1, clamped to the output width.
    function automatic void model_accept();
        longint a, b, c, d, re, im, lim;
        int     ch;
        beat_t  e;
        a = longint'(signed'(s_tdata[15:0]));
        b = longint'(signed'(s_tdata[31:16]));
        for (int k = 0; k < 3; k++) begin
            ch = m_ch[k];
            c  = m_hi[k][ch];
            d  = m_hq[k][ch];
            if (m_hv[k][ch]) begin
                re  = (a * c + b * d) >>> 1;
                im  = (b * c - a * d) >>> 1;
                lim = longint'(1) << (outw[k] - 1);
                if (re > lim - 1) re = lim - 1;
                if (re < -lim)    re = -lim;
                if (im > lim - 1) im = lim - 1;
                if (im < -lim)    im = -lim;
            end else begin
                re = 0;
                im = 0;
            end
            e.re = re; e.im = im; e.user = ch; e.last = s_tlast;
            exp_q[k].push_back(e);
            if (s_tlast && rot[k]) begin
                for (int j = 0; j < 16; j++) m_hv[k][j] = 1'b0;
            end else begin
                m_hi[k][ch] = a;
                m_hq[k][ch] = b;
                m_hv[k][ch] = 1'b1;
            end
            m_ch[k] = s_tlast ? 0 : (ch + 1) % nch[k];
        end
    endfunction

    function automatic void get_out(input int k, output bit v, output beat_t b);
        case (k)
            0: begin
                v = m_tvalid0; b.re = longint'(signed'(m_tdata0[31:0]));
                b.im = longint'(signed'(m_tdata0[63:32])); b.user = int'(m_tuser0); b.last = m_tlast0;
            end
            1: begin
                v = m_tvalid1; b.re = longint'(signed'(m_tdata1[31:0]));
                b.im = longint'(signed'(m_tdata1[63:32])); b.user = int'(m_tuser1); b.last = m_tlast1;
            end
            default: begin
                v = m_tvalid2; b.re = longint'(signed'(m_tdata2[15:0]));
                b.im = longint'(signed'(m_tdata2[31:16])); b.user = int'(m_tuser2); b.last = m_tlast2;
            end
        endcase
    endfunction

    function automatic void monitor();
        bit    v;
        beat_t b, e;
        chk("tready_agree_dut1", longint'(s_tready1), longint'(s_tready0));
        chk("tready_agree_dut2", longint'(s_tready2), longint'(s_tready0));
        for (int k = 0; k < 3; k++) begin
            get_out(k, v, b);
            if (held_v[k]) begin
                chk($sformatf("stall_valid_dut%0d", k), longint'(v), 1);
                chk($sformatf("stall_re_dut%0d", k), b.re, held[k].re);
                chk($sformatf("stall_im_dut%0d", k), b.im, held[k].im);
                chk($sformatf("stall_user_dut%0d", k), b.user, held[k].user);
            end
            held_v[k] = v && !m_tready;
            held[k]   = b;
            if (v && m_tready) begin
                log_q[k].push_back(b);
                if (exp_q[k].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat dut%0d got re %0d im %0d, none expected", k, b.re, b.im);
                end else begin
                    e = exp_q[k].pop_front();
                    chk($sformatf("model_re_dut%0d", k), b.re, e.re);
                    chk($sformatf("model_im_dut%0d", k), b.im, e.im);
                    chk($sformatf("model_user_dut%0d", k), b.user, e.user);
                    chk($sformatf("model_last_dut%0d", k), longint'(b.last), longint'(e.last));
                end
                if (k == 0) chk("tstrb_dut0", longint'(m_tstrb0), 255);
            end
        end
    endfunction

    // Sample on the falling edge, return just after the next rising edge.
    task automatic tick(output bit acc);
        @(negedge clk);
        acc = rst_n && s_tvalid && s_tready0;
        if (rst_n) begin
            if (acc) model_accept();
            monitor();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int i, input int q, input bit last);
        iq_t pk;
        pk.re = i[15:0];
        pk.im = q[15:0];
        s_tdata = pk;
        s_tlast = last;
        s_tvalid = 1'b1;
    endtask

    task automatic send_beat(input int i, input int q, input bit last);
        bit acc;
        set_beat(i, q, last);
        for (int n = 0; n < 200; n++) begin
            tick(acc);
            if (acc) return;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout got no accept want accept within 200 cycles");
    endtask

    task automatic drain();
        bit acc;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0 && !m_tvalid0) return;
            tick(acc);
        end
        checks++;
        errors++;
        $display("FAIL drain_timeout got %0d beats pending want 0", exp_q[0].size());
    endtask

    task automatic do_reset();
        bit acc;
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        model_clear();
        repeat (2) tick(acc);
        rst_n = 1'b1;
    endtask

    function automatic void add(int grp, int i, int q, bit last, int dut, longint re, longint im, int user);
        vec_t v;
        v.grp = grp; v.i = i; v.q = q; v.last = last; v.dut = dut; v.re = re; v.im = im; v.user = user;
        vecs.push_back(v);
    endfunction

    task automatic run_table();
        int lo, hi, pos, d;
        lo = 0;
        while (lo < vecs.size()) begin
            hi = lo;
            while (hi + 1 < vecs.size() && vecs[hi + 1].grp == vecs[lo].grp) hi++;
            do_reset();
            m_tready = 1'b1;
            for (int j = lo; j <= hi; j++) send_beat(vecs[j].i, vecs[j].q, vecs[j].last);
            drain();
            for (int j = lo; j <= hi; j++) begin
                d = vecs[j].dut;
                pos = j - lo;
                if (d >= 0) begin
                    if (pos >= log_q[d].size()) begin
                        checks++;
                        errors++;
                        $display("FAIL vec_missing grp %0d beat %0d got no output want one", vecs[j].grp, pos);
                    end else begin
                        chk($sformatf("vec_re_g%0d_b%0d", vecs[j].grp, pos), log_q[d][pos].re, vecs[j].re);
                        chk($sformatf("vec_im_g%0d_b%0d", vecs[j].grp, pos), log_q[d][pos].im, vecs[j].im);
                        chk($sformatf("vec_user_g%0d_b%0d", vecs[j].grp, pos), log_q[d][pos].user, vecs[j].user);
                    end
                end
            end
            lo = hi + 1;
        end
    endtask

    initial begin
        bit acc;
        int n_acc, cyc;
        rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tstrb = 4'hF; m_tready = 1'b1;
        model_clear();
        repeat (2) tick(acc);
        chk("reset_tvalid", longint'(m_tvalid0), 0);
        chk("reset_tdata", longint'(m_tdata0), 0);
        chk("reset_tstrb", longint'(m_tstrb0), 0);
        chk("reset_tuser", longint'(m_tuser0), 0);
        chk("reset_s_tready", longint'(s_tready0), 1);
        rst_n = 1'b1;

        // Directed vectors: group, I, Q, tlast, checked dut, expected real, imag, tuser.
        add(1, 1000, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1000, 0, 0, 0, 500000, 0);
        add(2, 100, 0, 0, 1, 0, 0, 0);
        add(2, 0, 100, 0, 1, 0, 0, 1);
        add(2, 100, 0, 0, 1, 5000, 0, 0);
        add(2, 0, -100, 0, 1, -5000, 0, 1);
        add(3, 32767, 0, 0, 2, 0, 0, 0);
        add(3, 32767, 0, 0, 2, 32767, 0, 0);
        add(3, -32768, 0, 0, 2, -32768, 0, 0);
        add(4, 10, 20, 0, 0, 0, 0, 0);
        add(4, 30, 40, 0, 0, 550, -100, 0);
        add(4, 50, 60, 1, 0, 1950, -100, 0);
        add(4, 70, 80, 0, 0, 0, 0, 0);
        add(5, 10, 20, 0, -1, 0, 0, 0);
        add(5, 30, 40, 0, -1, 0, 0, 0);
        add(5, 50, 60, 1, 1, 850, -200, 0);
        add(5, 70, 80, 0, 1, 4150, -100, 0);
        run_table();

        // Latency: beat accepted at edge 0 shows up after edge 1, not before.
        do_reset();
        set_beat(7, 3, 0);
        tick(acc);
        chk("lat_accept", longint'(acc), 1);
        s_tvalid = 1'b0;
        chk("lat_cycle1_tvalid", longint'(m_tvalid0), 0);
        tick(acc);
        chk("lat_cycle2_tvalid", longint'(m_tvalid0), 1);
        drain();

        // Stall during a 10-beat burst: exactly two beats absorbed, then input stalls.
        do_reset();
        m_tready = 1'b0;
        n_acc = 0;
        set_beat(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), 0);
        for (int c = 0; c < 6; c++) begin
            tick(acc);
            if (acc) begin
                n_acc++;
                set_beat(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), 0);
            end
        end
        chk("stall_accepted", n_acc, 2);
        chk("stall_s_tready", longint'(s_tready0), 0);
        m_tready = 1'b1;
        for (int c = 0; c < 100 && n_acc < 10; c++) begin
            tick(acc);
            if (acc) begin
                n_acc++;
                set_beat(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), 0);
            end
        end
        drain();
        chk("burst_outputs", log_q[0].size(), 10);

        // Random soak: random valid, ready, data and frame boundaries against the model.
        do_reset();
        s_tvalid = 1'b0;
        acc = 1'b0;
        for (cyc = 0; cyc < 1500; cyc++) begin
            if (!s_tvalid || acc) begin
                if ($urandom_range(0, 3) != 0)
                    set_beat(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                             ($urandom_range(0, 9) == 0));
                else
                    s_tvalid = 1'b0;
            end
            m_tready = ($urandom_range(0, 2) != 0);
            tick(acc);
        end
        drain();
        chk("soak_pending", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);

        // Reset asserted mid-burst clears outputs at once; first beat afterwards has no history.
        do_reset();
        for (int j = 0; j < 5; j++) send_beat(int'($urandom_range(1, 9000)), int'($urandom_range(1, 9000)), 0);
        chk("midrst_pre_tvalid", longint'(m_tvalid0), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_tvalid", longint'(m_tvalid0), 0);
        chk("midrst_tdata", longint'(m_tdata0), 0);
        chk("midrst_tlast", longint'(m_tlast0), 0);
        chk("midrst_tuser", longint'(m_tuser0), 0);
        s_tvalid = 1'b0;
        model_clear();
        repeat (2) tick(acc);
        rst_n = 1'b1;
        send_beat(123, -45, 0);
        drain();
        if (log_q[0].size() != 1) begin
            checks++;
            errors++;
            $display("FAIL postrst_count got %0d want 1", log_q[0].size());
        end else begin
            chk("postrst_re", log_q[0][0].re, 0);
            chk("postrst_im", log_q[0][0].im, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
